// File: rtl/avalon_pio_master.sv
// avalon_pio_master: single-outstanding Avalon-MM initiator for PIO-style slaves.
// Local side: cmd_valid/cmd_ready command handshake, one rsp_valid pulse per command.
// Bus side: avm_chipselect, active-low avm_write_n/avm_read_n, avm_address,
//   avm_writedata, avm_readdata, avm_waitrequest. All bus outputs are registered.
// Status: busy (state != IDLE), rsp_err flags a waitrequest timeout abort.
// Clock/reset: clk rising edge, reset_n asynchronous active-low.
module avalon_pio_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_LAT,
        S_RESP
    } state_t;

    // Abort fires on the stall cycle that would make the count reach TIMEOUT.
    localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);
    localparam logic [1:0]  LAT_N     = 2'(READ_LATENCY);

    state_t            r_state, w_state;
    logic              r_cs, w_cs;
    logic              r_write_n, w_write_n;
    logic              r_read_n, w_read_n;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic [DATA_W-1:0] r_rdata, w_rdata;
    logic              r_err, w_err;
    logic              r_rsp_valid, w_rsp_valid;
    logic              r_is_write, w_is_write;
    logic [15:0]       r_stall, w_stall;
    logic [1:0]        r_lat, w_lat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cs        <= 1'b0;
            r_write_n   <= 1'b1;
            r_read_n    <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_is_write  <= 1'b0;
            r_stall     <= '0;
            r_lat       <= '0;
        end else begin
            r_state     <= w_state;
            r_cs        <= w_cs;
            r_write_n   <= w_write_n;
            r_read_n    <= w_read_n;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_rdata     <= w_rdata;
            r_err       <= w_err;
            r_rsp_valid <= w_rsp_valid;
            r_is_write  <= w_is_write;
            r_stall     <= w_stall;
            r_lat       <= w_lat;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cs        = r_cs;
        w_write_n   = r_write_n;
        w_read_n    = r_read_n;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_rdata     = r_rdata;
        w_err       = r_err;
        w_rsp_valid = 1'b0;
        w_is_write  = r_is_write;
        w_stall     = r_stall;
        w_lat       = r_lat;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_addr     = cmd_addr;
                    w_wdata    = cmd_wdata;
                    w_cs       = 1'b1;
                    w_write_n  = ~cmd_write;
                    w_read_n   = cmd_write;
                    w_is_write = cmd_write;
                    w_stall    = '0;
                    w_rdata    = '0;
                    w_err      = 1'b0;
                    w_state    = S_BUS;
                end
            end
            S_BUS: begin
                if (avm_waitrequest) begin
                    if (r_stall == STALL_MAX) begin
                        w_cs        = 1'b0;
                        w_write_n   = 1'b1;
                        w_read_n    = 1'b1;
                        w_err       = 1'b1;
                        w_rdata     = '0;
                        w_rsp_valid = 1'b1;
                        w_state     = S_RESP;
                    end else begin
                        w_stall = r_stall + 16'd1;
                    end
                end else begin
                    w_cs      = 1'b0;
                    w_write_n = 1'b1;
                    w_read_n  = 1'b1;
                    if (r_is_write) begin
                        w_rsp_valid = 1'b1;
                        w_state     = S_RESP;
                    end else if (READ_LATENCY == 0) begin
                        w_rdata     = avm_readdata;
                        w_rsp_valid = 1'b1;
                        w_state     = S_RESP;
                    end else begin
                        // r_lat counts cycles since the completion cycle.
                        w_lat   = 2'd1;
                        w_state = S_LAT;
                    end
                end
            end
            S_LAT: begin
                if (r_lat == LAT_N) begin
                    w_rdata     = avm_readdata;
                    w_rsp_valid = 1'b1;
                    w_state     = S_RESP;
                end else begin
                    w_lat = r_lat + 2'd1;
                end
            end
            S_RESP: begin
                w_rdata = '0;
                w_err   = 1'b0;
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign cmd_ready      = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rdata;
    assign rsp_err        = r_err;
    assign avm_address    = r_addr;
    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_write_n;
    assign avm_read_n     = r_read_n;
    assign avm_writedata  = r_wdata;

endmodule

// File: tb/tb_avalon_pio_master.sv
// tb_avalon_pio_master: scoreboard bench for avalon_pio_master with a PIO
// slave model (register at address 0) that has programmable stall and latency.
module tb_avalon_pio_master;

    localparam int AW = 2;
    localparam int DW = 32;
    localparam int RL = 2;
    localparam int TO = 8;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic          avm_read_n;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    avalon_pio_master #(
        .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
        int            strobes;
    } exp_t;

    exp_t          q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            cur_stall = 0;
    int            wcnt = 0;
    int            scount = 0;
    int            accepts = 0;
    int            rsps = 0;
    logic [DW-1:0] exp_reg = '0;

    // Slave model: one register at address 0, reads elsewhere return 0.
    logic [DW-1:0] sreg = '0;
    logic [DW-1:0] pipe [0:RL-1];
    logic          pv [0:RL-1];
    logic          rd_done, wr_done;

    assign avm_waitrequest = avm_chipselect && (wcnt < cur_stall);
    assign rd_done = avm_chipselect && !avm_read_n && !avm_waitrequest;
    assign wr_done = avm_chipselect && !avm_write_n && !avm_waitrequest;
    assign avm_readdata = pv[RL-1] ? pipe[RL-1] : 32'hDEAD_BEEF;

    initial begin
        for (int i = 0; i < RL; i++) begin
            pipe[i] = '0;
            pv[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        wcnt <= avm_chipselect ? wcnt + 1 : 0;
        pv[0] <= rd_done;
        pipe[0] <= (avm_address == 0) ? sreg : '0;
        for (int i = 1; i < RL; i++) begin
            pv[i] <= pv[i-1];
            pipe[i] <= pipe[i-1];
        end
        if (wr_done && avm_address == 0)
            sreg <= avm_writedata;
    end

    always @(negedge clk) begin
        if (!reset_n) scount = 0;
        if (cmd_valid && cmd_ready) accepts++;
        vectors++;
        if (!avm_write_n && !avm_read_n) begin
            $display("FAIL strobes_both act=%b%b req=11",
                     avm_write_n, avm_read_n);
            miscompares++;
        end
        vectors++;
        if ((!avm_write_n || !avm_read_n) && !avm_chipselect) begin
            $display("FAIL strobe_no_cs act_cs=%b req=1", avm_chipselect);
            miscompares++;
        end
        vectors++;
        if (cmd_ready !== !busy) begin
            $display("FAIL ready_busy act=%b req=%b", cmd_ready, !busy);
            miscompares++;
        end
        if (!avm_write_n || !avm_read_n) begin
            scount++;
            vectors++;
            if (q.size() == 0) begin
                $display("FAIL stray_strobe act=1 req=0");
                miscompares++;
            end else begin
                if (avm_address !== q[0].addr ||
                    avm_write_n !== !q[0].wr ||
                    (q[0].wr && avm_writedata !== q[0].wdata)) begin
                    $display("FAIL bus_fields act=%h/%b/%h req=%h/%b/%h",
                             avm_address, avm_write_n, avm_writedata,
                             q[0].addr, !q[0].wr, q[0].wdata);
                    miscompares++;
                end
            end
        end
        if (rsp_valid) begin
            rsps++;
            vectors++;
            if (q.size() == 0) begin
                $display("FAIL stray_rsp act=1 req=0");
                miscompares++;
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rsp_rdata !== e.rdata) begin
                    $display("FAIL rsp_rdata act=%h req=%h",
                             rsp_rdata, e.rdata);
                    miscompares++;
                end
                vectors++;
                if (rsp_err !== e.err) begin
                    $display("FAIL rsp_err act=%b req=%b", rsp_err, e.err);
                    miscompares++;
                end
                vectors++;
                if (cyc != e.cyc) begin
                    $display("FAIL rsp_cycle act=%0d req=%0d", cyc, e.cyc);
                    miscompares++;
                end
                vectors++;
                if (scount != e.strobes) begin
                    $display("FAIL strobe_len act=%0d req=%0d",
                             scount, e.strobes);
                    miscompares++;
                end
            end
            scount = 0;
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int st);
        exp_t e;
        int n;
        logic tmo;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 200);
        vectors++;
        if (!cmd_ready) begin
            $display("FAIL accept act=0 req=1");
            miscompares++;
            cmd_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        cur_stall = st;
        tmo = (st >= TO);
        e.wr      = wr;
        e.addr    = a;
        e.wdata   = d;
        e.err     = tmo;
        e.rdata   = (wr || tmo || a != 0) ? '0 : exp_reg;
        e.cyc     = tmo ? cyc + 1 + TO : cyc + 2 + st + (wr ? 0 : RL);
        e.strobes = tmo ? TO : st + 1;
        if (wr && !tmo && a == 0) exp_reg = d;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (q.size() != 0 || busy) begin
            $display("FAIL drain act=%0d req=0", q.size());
            miscompares++;
            q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_read_n, busy, cmd_ready}
            !== 5'b01101) begin
            $display("FAIL reset_ctl act=%b req=01101",
                     {avm_chipselect, avm_write_n, avm_read_n,
                      busy, cmd_ready});
            miscompares++;
        end
        vectors++;
        if (avm_address !== '0 || avm_writedata !== '0 ||
            rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
            $display("FAIL reset_data act=%h/%h/%b/%h/%b req=0",
                     avm_address, avm_writedata, rsp_valid,
                     rsp_rdata, rsp_err);
            miscompares++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        issue(1'b1, 2'd0, 32'h0000_0002, 0);
        cmd_valid = 1'b0;
        wait_idle();
        vectors++;
        if (sreg[1:0] !== 2'b10) begin
            $display("FAIL out_port act=%b req=10", sreg[1:0]);
            miscompares++;
        end
    endtask

    task automatic test_read();
        issue(1'b0, 2'd0, '0, 0);
        cmd_valid = 1'b0;
        wait_idle();
        issue(1'b0, 2'd1, '0, 0);
        cmd_valid = 1'b0;
        wait_idle();
        issue(1'b1, 2'd0, 32'hA5A5_0003, 0);
        issue(1'b0, 2'd0, '0, 0);
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_waitrequest();
        issue(1'b0, 2'd0, '0, 3);
        cmd_valid = 1'b0;
        wait_idle();
        issue(1'b1, 2'd0, 32'h1234_5678, 2);
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_timeout();
        issue(1'b1, 2'd0, 32'hFFFF_FFFF, 1000);
        cmd_valid = 1'b0;
        wait_idle();
        issue(1'b0, 2'd0, '0, 0);
        cmd_valid = 1'b0;
        wait_idle();
        issue(1'b0, 2'd0, '0, TO - 1);
        cmd_valid = 1'b0;
        wait_idle();
        issue(1'b1, 2'd0, 32'h0BAD_0BAD, TO);
        cmd_valid = 1'b0;
        wait_idle();
        issue(1'b1, 2'd0, 32'h0000_0001, TO - 1);
        issue(1'b0, 2'd0, '0, 0);
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int a0, r0;
        a0 = accepts;
        r0 = rsps;
        issue(1'b1, 2'd0, 32'h0000_00C3, 0);
        issue(1'b0, 2'd0, '0, 1);
        issue(1'b1, 2'd2, 32'h5555_5555, 0);
        issue(1'b0, 2'd0, '0, 0);
        cmd_valid = 1'b0;
        wait_idle();
        vectors++;
        if (accepts - a0 != 4) begin
            $display("FAIL b2b_accepts act=%0d req=4", accepts - a0);
            miscompares++;
        end
        vectors++;
        if (rsps - r0 != 4) begin
            $display("FAIL b2b_rsps act=%0d req=4", rsps - r0);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 2'd0, 32'h0000_0003, 1000);
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({avm_chipselect, avm_write_n, avm_read_n, busy}
            !== 4'b0110) begin
            $display("FAIL mid_reset act=%b req=0110",
                     {avm_chipselect, avm_write_n, avm_read_n, busy});
            miscompares++;
        end
        q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
                $display("FAIL post_reset act=%b%b req=01",
                         rsp_valid, cmd_ready);
                miscompares++;
            end
        end
        @(posedge clk);
        #1;
        issue(1'b0, 2'd0, '0, 0);
        cmd_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_waitrequest();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

endmodule
